// File: rtl/controle_multiciclo.sv
// controle_multiciclo
// Multicycle control FSM for the IR/PC/register-bank/ULA datapath.
// Sequence: BUSCA (fetch, stalls on mem_pronto) -> DECOD -> class-specific
// execute -> optional ESCRITA -> BUSCA. Halt traps in PARADO until reset;
// illegal opcodes set a sticky flag and retire as NOPs.
//
// Ports:
//   clk, reset_n      clock (rising edge) and synchronous active-low reset
//   opcode            IR opcode field (sampled in DECOD only)
//   mem_pronto        instruction memory data valid
//   mem_le            instruction memory read request
//   EscIR, EscCP      IR write / PC unconditional write
//   EscCondCP         PC conditional write (gated by ULA zero in datapath)
//   EscReg            register bank write
//   ULA_A, ULA_B      ULA operand selects
//   ULA_OP            ULA operation
//   FonteCP           PC source select
//   flagimm           immediate select for ULA_B=00
//   op_invalido       sticky illegal-opcode flag
//   parado            core halted
//   instr_ret         retired-instruction counter (wraps)
module controle_multiciclo #(
    parameter int OPCODE_W = 4,
    parameter int ULA_OP_W = 4,
    parameter int ULA_SOMA = 0,
    parameter int OP_JUMP  = 11,
    parameter int OP_BEQ   = 12,
    parameter int OP_HALT  = 15,
    parameter int CONT_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_pronto,
    output logic                mem_le,
    output logic                EscIR,
    output logic                EscCP,
    output logic                EscCondCP,
    output logic                EscReg,
    output logic                ULA_A,
    output logic [1:0]          ULA_B,
    output logic [ULA_OP_W-1:0] ULA_OP,
    output logic [1:0]          FonteCP,
    output logic                flagimm,
    output logic                op_invalido,
    output logic                parado,
    output logic [CONT_W-1:0]   instr_ret
);

    typedef enum logic [3:0] {
        BUSCA, DECOD, EXEC_R, EXEC_I, ESCRITA, DESVIO, BEQ, INVALIDO, PARADO
    } estado_t;

    localparam logic [ULA_OP_W-1:0] SOMA = ULA_OP_W'(ULA_SOMA);

    estado_t               estado_reg, estado_next;
    logic [OPCODE_W-1:0]   op_reg;
    logic [ULA_OP_W-1:0]   op_ula;
    logic                  op_invalido_reg;
    logic [CONT_W-1:0]     instr_ret_reg;

    // op_reg zero-extended or truncated onto the ULA operation width
    generate
        if (ULA_OP_W > OPCODE_W) begin : g_ext
            assign op_ula = {{(ULA_OP_W-OPCODE_W){1'b0}}, op_reg};
        end else begin : g_trunc
            assign op_ula = op_reg[ULA_OP_W-1:0];
        end
    endgenerate

    function automatic estado_t decodifica(input logic [OPCODE_W-1:0] op);
        logic [31:0] v;
        v = 32'(op);
        if (v > 32'd15)                 return INVALIDO;
        if (v == 32'(OP_JUMP))          return DESVIO;
        if (v == 32'(OP_BEQ))           return BEQ;
        if (v == 32'(OP_HALT))          return PARADO;
        case (v)
            32'd0, 32'd1, 32'd3, 32'd4, 32'd5:             return EXEC_R;
            32'd2, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10:     return EXEC_I;
            default:                                        return INVALIDO;
        endcase
    endfunction

    // ESCRITA has no memory of which EXEC it came from, so the immediate
    // select is re-derived from the latched opcode.
    function automatic logic eh_imediato(input logic [OPCODE_W-1:0] op);
        return decodifica(op) == EXEC_I;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_reg      <= BUSCA;
            op_reg          <= '0;
            op_invalido_reg <= 1'b0;
            instr_ret_reg   <= '0;
        end else begin
            estado_reg <= estado_next;
            if (estado_reg == DECOD)
                op_reg <= opcode;
            if (estado_reg == INVALIDO)
                op_invalido_reg <= 1'b1;
            // these states always return to BUSCA, retiring the instruction
            if (estado_reg == ESCRITA || estado_reg == DESVIO ||
                estado_reg == BEQ     || estado_reg == INVALIDO)
                instr_ret_reg <= instr_ret_reg + 1'b1;
        end
    end

    assign op_invalido = op_invalido_reg;
    assign instr_ret   = instr_ret_reg;

    always_comb begin
        estado_next = BUSCA;
        case (estado_reg)
            BUSCA:    estado_next = mem_pronto ? DECOD : BUSCA;
            DECOD:    estado_next = decodifica(opcode);
            EXEC_R,
            EXEC_I:   estado_next = ESCRITA;
            PARADO:   estado_next = PARADO;
            default:  estado_next = BUSCA;
        endcase
    end

    always_comb begin
        mem_le    = 1'b0;
        EscIR     = 1'b0;
        EscCP     = 1'b0;
        EscCondCP = 1'b0;
        EscReg    = 1'b0;
        ULA_A     = 1'b0;
        ULA_B     = 2'b00;
        ULA_OP    = SOMA;
        FonteCP   = 2'b00;
        flagimm   = 1'b0;
        parado    = 1'b0;
        case (estado_reg)
            BUSCA: begin
                mem_le = 1'b1;
                ULA_B  = 2'b01;
                EscIR  = mem_pronto;
                EscCP  = mem_pronto;
            end
            DECOD: begin
                // PC + offset precomputed into ULA_SAIDA for a possible BEQ
                ULA_B = 2'b10;
            end
            EXEC_R, EXEC_I, ESCRITA: begin
                ULA_A   = 1'b1;
                ULA_OP  = op_ula;
                flagimm = eh_imediato(op_reg);
                EscReg  = (estado_reg == ESCRITA);
            end
            DESVIO: begin
                EscCP   = 1'b1;
                FonteCP = 2'b10;
                ULA_B   = 2'b10;
            end
            BEQ: begin
                ULA_A     = 1'b1;
                ULA_OP    = op_ula;
                EscCondCP = 1'b1;
                FonteCP   = 2'b01;
            end
            PARADO: begin
                parado = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       mem_pronto = 1'b0;
    logic [3:0] opcode = 4'd0;

    logic mem_le, EscIR, EscCP, EscCondCP, EscReg, ULA_A, flagimm, op_invalido, parado;
    logic [1:0]  ULA_B, FonteCP;
    logic [3:0]  ULA_OP;
    logic [15:0] instr_ret;

    logic mem_le_b, EscIR_b, EscCP_b, EscCondCP_b, EscReg_b, ULA_A_b, flagimm_b, op_invalido_b, parado_b;
    logic [1:0] ULA_B_b, FonteCP_b;
    logic [3:0] ULA_OP_b;
    logic [1:0] instr_ret_b;

    controle_multiciclo u_dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_pronto(mem_pronto),
        .mem_le(mem_le), .EscIR(EscIR), .EscCP(EscCP), .EscCondCP(EscCondCP),
        .EscReg(EscReg), .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_OP(ULA_OP),
        .FonteCP(FonteCP), .flagimm(flagimm), .op_invalido(op_invalido),
        .parado(parado), .instr_ret(instr_ret)
    );

    controle_multiciclo #(.CONT_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_pronto(mem_pronto),
        .mem_le(mem_le_b), .EscIR(EscIR_b), .EscCP(EscCP_b), .EscCondCP(EscCondCP_b),
        .EscReg(EscReg_b), .ULA_A(ULA_A_b), .ULA_B(ULA_B_b), .ULA_OP(ULA_OP_b),
        .FonteCP(FonteCP_b), .flagimm(flagimm_b), .op_invalido(op_invalido_b),
        .parado(parado_b), .instr_ret(instr_ret_b)
    );

    logic [16:0] got_a, got_b;
    assign got_a = {mem_le, EscIR, EscCP, EscCondCP, EscReg, ULA_A, ULA_B, ULA_OP,
                    FonteCP, flagimm, op_invalido, parado};
    assign got_b = {mem_le_b, EscIR_b, EscCP_b, EscCondCP_b, EscReg_b, ULA_A_b, ULA_B_b,
                    ULA_OP_b, FonteCP_b, flagimm_b, op_invalido_b, parado_b};

    int total = 0;
    int bad   = 0;

    // Instruction-level model: phase within the current instruction,
    // the latched opcode, and the architectural flags/counters.
    int         m_fase  = 0;
    logic [3:0] m_op    = 4'd0;
    logic       m_parado = 1'b0;
    logic       m_inv   = 1'b0;
    int         m_ret   = 0;
    logic       m_known = 1'b0;

    localparam int C_R = 0, C_I = 1, C_J = 2, C_BQ = 3, C_HALT = 4, C_ILL = 5;

    function automatic int classe(input logic [3:0] op);
        if (op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5}) return C_R;
        if (op inside {4'd2, [4'd6:4'd10]})          return C_I;
        if (op == 4'd11) return C_J;
        if (op == 4'd12) return C_BQ;
        if (op == 4'd15) return C_HALT;
        return C_ILL;
    endfunction

    function automatic logic [16:0] esperado(input logic mp);
        logic le, ir, cp, ccp, wr, a, fi;
        logic [1:0] b, fcp;
        logic [3:0] uop;
        int c;
        le = 0; ir = 0; cp = 0; ccp = 0; wr = 0; a = 0; fi = 0;
        b = 2'b00; fcp = 2'b00; uop = 4'd0;
        if (m_parado)
            return {6'b0, 2'b00, 4'd0, 2'b00, 1'b0, m_inv, 1'b1};
        if (m_fase == 0) begin
            le = 1; b = 2'b01; ir = mp; cp = mp;
        end else if (m_fase == 1) begin
            b = 2'b10;
        end else begin
            c = classe(m_op);
            if (c == C_R || c == C_I) begin
                a = 1; uop = m_op; fi = (c == C_I); wr = (m_fase == 3);
            end else if (c == C_J) begin
                cp = 1; fcp = 2'b10; b = 2'b10;
            end else if (c == C_BQ) begin
                a = 1; uop = m_op; ccp = 1; fcp = 2'b01;
            end
        end
        return {le, ir, cp, ccp, wr, a, b, uop, fcp, fi, m_inv, 1'b0};
    endfunction

    task automatic model_update(input logic rn, input logic mp, input logic [3:0] op);
        int c, len;
        if (!rn) begin
            m_fase = 0; m_parado = 0; m_inv = 0; m_ret = 0; m_op = 4'd0; m_known = 1;
            return;
        end
        if (m_parado) return;
        if (m_fase == 0) begin
            if (mp) m_fase = 1;
        end else if (m_fase == 1) begin
            m_op = op;
            if (classe(op) == C_HALT) m_parado = 1;
            else m_fase = 2;
        end else begin
            c = classe(m_op);
            len = (c == C_R || c == C_I) ? 4 : 3;
            if (c == C_ILL) m_inv = 1;
            if (m_fase == len - 1) begin
                m_fase = 0;
                m_ret++;
            end else begin
                m_fase++;
            end
        end
    endtask

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        total++;
        if (atual !== esp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", nome, atual, esp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("saidas", 32'(got_a), 32'(esperado(mem_pronto)));
            chk("saidas_b", 32'(got_b), 32'(esperado(mem_pronto)));
            chk("instr_ret", 32'(instr_ret), 32'(m_ret % 65536));
            chk("instr_ret_b", 32'(instr_ret_b), 32'(m_ret % 4));
        end
    end

    task automatic drive(input logic rn, input logic mp, input logic [3:0] op);
        reset_n = rn; mem_pronto = mp; opcode = op;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(reset_n, mem_pronto, opcode);
        #1;
    endtask

    task automatic cyc(input logic rn, input logic mp, input logic [3:0] op);
        drive(rn, mp, op);
        tick();
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    task automatic exec_op(input logic [3:0] op);
        int n;
        cyc(1, 1, rop());
        cyc(1, rb(), op);
        n = (classe(op) == C_R || classe(op) == C_I) ? 2 : 1;
        for (int i = 0; i < n; i++) cyc(1, rb(), rop());
    endtask

    initial begin
        cyc(0, 0, 4'd0);

        // stall in fetch
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, rop());
            chk("stall_mem_le", 32'(mem_le), 32'd1);
            chk("stall_EscIR", 32'(EscIR), 32'd0);
            chk("stall_EscCP", 32'(EscCP), 32'd0);
            chk("stall_ret", 32'(instr_ret), 32'd0);
            tick();
        end

        // R-type opcode 4
        drive(1, 1, rop()); chk("r_EscIR", 32'(EscIR), 32'd1); chk("r_EscCP", 32'(EscCP), 32'd1); tick();
        cyc(1, rb(), 4'd4);
        drive(1, rb(), rop()); chk("r_exec_op", 32'(ULA_OP), 32'd4); chk("r_exec_fi", 32'(flagimm), 32'd0); tick();
        drive(1, rb(), rop()); chk("r_EscReg", 32'(EscReg), 32'd1); chk("r_wb_op", 32'(ULA_OP), 32'd4); tick();
        drive(1, 0, rop()); chk("r_ret", 32'(instr_ret), 32'd1); tick();

        // I-type opcode 7
        cyc(1, 1, rop());
        cyc(1, rb(), 4'd7);
        drive(1, rb(), rop()); chk("i_exec_fi", 32'(flagimm), 32'd1); chk("i_exec_op", 32'(ULA_OP), 32'd7); tick();
        drive(1, rb(), rop()); chk("i_wb_fi", 32'(flagimm), 32'd1); chk("i_EscReg", 32'(EscReg), 32'd1); tick();
        drive(1, 0, rop()); chk("i_ret", 32'(instr_ret), 32'd2); tick();

        // jump
        cyc(1, 1, rop());
        cyc(1, rb(), 4'd11);
        drive(1, rb(), rop());
        chk("j_EscCP", 32'(EscCP), 32'd1); chk("j_FonteCP", 32'(FonteCP), 32'd2); chk("j_EscReg", 32'(EscReg), 32'd0);
        tick();
        drive(1, 0, rop()); chk("j_ret", 32'(instr_ret), 32'd3); tick();

        // BEQ
        cyc(1, 1, rop());
        cyc(1, rb(), 4'd12);
        drive(1, rb(), rop());
        chk("beq_EscCondCP", 32'(EscCondCP), 32'd1); chk("beq_FonteCP", 32'(FonteCP), 32'd1);
        chk("beq_op", 32'(ULA_OP), 32'd12); chk("beq_EscCP", 32'(EscCP), 32'd0);
        tick();

        // illegal opcode 13
        cyc(1, 1, rop());
        drive(1, rb(), 4'd13); chk("ill_we1", 32'({EscIR, EscCP, EscCondCP, EscReg}), 32'd0); tick();
        drive(1, rb(), rop()); chk("ill_we2", 32'({EscIR, EscCP, EscCondCP, EscReg}), 32'd0); tick();
        drive(1, 0, rop()); chk("ill_flag", 32'(op_invalido), 32'd1); chk("ill_ret", 32'(instr_ret), 32'd5); tick();
        exec_op(4'd4);
        drive(1, 0, rop()); chk("ill_sticky", 32'(op_invalido), 32'd1); tick();

        // halt, then reset out of it
        cyc(1, 1, rop());
        cyc(1, rb(), 4'd15);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, rop());
            chk("halt_parado", 32'(parado), 32'd1); chk("halt_mem_le", 32'(mem_le), 32'd0);
            tick();
        end
        cyc(0, 1, rop());
        drive(1, 0, rop());
        chk("rst_parado", 32'(parado), 32'd0); chk("rst_mem_le", 32'(mem_le), 32'd1);
        chk("rst_inv", 32'(op_invalido), 32'd0); chk("rst_ret", 32'(instr_ret), 32'd0);
        tick();

        // counter wrap on the 2-bit instance
        for (int i = 0; i < 5; i++) exec_op(4'd11);
        drive(1, 0, rop()); chk("wrap_b", 32'(instr_ret_b), 32'd1); chk("wrap_a", 32'(instr_ret), 32'd5); tick();

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            logic rn;
            rn = 1'b1;
            if (m_parado && $urandom_range(0, 7) == 0) rn = 1'b0;
            else if ($urandom_range(0, 299) == 0) rn = 1'b0;
            cyc(rn, ($urandom_range(0, 9) < 7), rop());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Parametrised multicycle control FSM for the datapath (IR, PC, register bank, ULA). It replaces purely opcode-decoded control with a sequenced fetch/decode/execute/writeback flow. Instruction fetch stalls on a memory-ready handshake. Illegal and halt opcodes are trapped, and a retired-instruction counter is maintained. All ULA/mux select encodings keep their existing meanings.

Parameters:
OPCODE_W, 4, opcode width; any opcode value above 15 is illegal
ULA_OP_W, 4, ULA operation width; op_reg is zero-extended or truncated to this width
ULA_SOMA, 0, ULA_OP code used for PC increment and branch-target add
OP_JUMP, 11, unconditional jump opcode
OP_BEQ, 12, conditional branch opcode
OP_HALT, 15, halt opcode
CONT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
opcode  in  OPCODE_W  IR opcode field, valid from the cycle after IR is written
mem_pronto  in  1  instruction memory data valid this cycle
mem_le  out  1  instruction memory read request
EscIR  out  1  IR write enable
EscCP  out  1  PC unconditional write enable
EscCondCP  out  1  PC conditional write enable (datapath gates it with ULA zero)
EscReg  out  1  register bank write enable
ULA_A  out  1  0=PC, 1=register A
ULA_B  out  2  00=register B/imm, 01=constant 1, 10=immediate offset
ULA_OP  out  ULA_OP_W  ULA operation
FonteCP  out  2  00=ULA result, 01=ULA_SAIDA register, 10=jump immediate
flagimm  out  1  selects immediate for ULA_B=00
op_invalido  out  1  sticky illegal-opcode flag
parado  out  1  core halted
instr_ret  out  CONT_W  retired-instruction count

Behaviour:
- Reset: reset_n low at a clk edge puts state in BUSCA, clears op_reg, op_invalido and instr_ret. Reset applies in any state, including mid-fetch and PARADO.
- Outputs are combinational from state, op_reg and mem_pronto. Every output not listed for a state is 0, except ULA_OP, which defaults to ULA_SOMA.
- op_reg captures opcode on the DECOD cycle only.
- BUSCA: mem_le=1, ULA_A=0, ULA_B=01, ULA_OP=ULA_SOMA, FonteCP=00. EscIR=EscCP=mem_pronto. If mem_pronto=1 go to DECOD, else stay; the state may stall indefinitely.
- DECOD: ULA_A=0, ULA_B=10, ULA_OP=ULA_SOMA (branch target latched in ULA_SAIDA). Next state decoded from the live opcode:
  - 0,1,3,4,5 -> EXEC_R
  - 2,6..10 -> EXEC_I
  - OP_JUMP -> DESVIO
  - OP_BEQ -> BEQ
  - OP_HALT -> PARADO
  - anything else -> INVALIDO
- EXEC_R: ULA_A=1, ULA_B=00, ULA_OP=op_reg, flagimm=0 -> ESCRITA.
- EXEC_I: same as EXEC_R with flagimm=1 -> ESCRITA.
- ESCRITA: EscReg=1; ULA_A, ULA_B, ULA_OP and flagimm held at the EXEC values for op_reg -> BUSCA.
- DESVIO: EscCP=1, FonteCP=10, ULA_B=10 -> BUSCA.
- BEQ: ULA_A=1, ULA_B=00, ULA_OP=op_reg, EscCondCP=1, FonteCP=01 -> BUSCA.
- INVALIDO: sets op_invalido (held until reset); no write enable asserted; instruction treated as NOP -> BUSCA.
- PARADO: parado=1, mem_le=0, all enables 0; remains until reset.
- Latency with mem_pronto=1 at first fetch cycle: R/I type = 4 cycles, jump/BEQ/illegal = 3 cycles. Each stall cycle adds 1.
- instr_ret increments by 1 on the cycle that leaves ESCRITA, DESVIO, BEQ or INVALIDO to BUSCA. HALT does not count. Wraps modulo 2^CONT_W with no saturation.
- EscCP and EscCondCP are never both 1. EscIR is never 1 outside BUSCA.

Test Plan:
- Reset, then hold mem_pronto=0 for 3 cycles -> state stays BUSCA; mem_le=1, EscIR=0, EscCP=0, instr_ret=0.
- Opcode 4, mem_pronto=1 -> EscIR/EscCP pulse at cycle 0, EscReg=1 at cycle 3 with ULA_OP=4, flagimm=0; instr_ret=1 at cycle 4.
- Opcode 7 -> identical timing to opcode 4 but flagimm=1 in EXEC and ESCRITA; opcode 11 -> FonteCP=10, EscCP=1 at cycle 2, no EscReg.
- Opcode 12 -> EscCondCP=1, FonteCP=01, ULA_OP=12 at cycle 2; EscCP=0 that cycle.
- Opcode 13 -> op_invalido=1 from cycle 3 and stays 1 through the following valid instructions; no write enable at cycles 1-2; instr_ret increments.
- Opcode 15 -> parado=1, mem_le=0 indefinitely; reset_n low for one edge -> BUSCA, parado=0. With CONT_W=2, 5 retired instructions -> instr_ret=1.
